banked_mem_ctrl: RTL and testbench

//   Four-bank interleaved main-memory stage directly downstream of the direct-mapped cache FSM.

---
 rtl/banked_mem_ctrl_pkg.sv | 27 ++
 rtl/banked_mem_ctrl_if.sv | 24 ++
 rtl/banked_mem_ctrl_timer.sv | 39 +++
 rtl/banked_mem_ctrl.sv | 81 ++++++++
 tb/tb_banked_mem_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/banked_mem_ctrl_pkg.sv
// Shared constants, bank-select helper and reject-cause encoding for the
// four-bank interleaved main-memory stage.
package mem_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int BANK_CYCLES = 4;
    localparam int RD_LATENCY  = 2;
    localparam int NUM_BANKS   = 4;
    localparam int BANK_W      = $clog2(NUM_BANKS);
    localparam int NUM_WORDS   = 2 ** (ADDR_W - 1);
    localparam int CNT_W       = (BANK_CYCLES > 1) ? $clog2(BANK_CYCLES) : 1;

    // Why a request was turned away; ERR_NONE means it was accepted or absent.
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_RD_WR     = 2'd1,
        ERR_MISALIGN  = 2'd2,
        ERR_BANK_BUSY = 2'd3
    } err_cause_e;

    // Word interleave: consecutive 16-bit words land in consecutive banks.
    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[2:1];
    endfunction

endpackage

// File: rtl/banked_mem_ctrl_if.sv
// Request/response bus between the cache FSM (master) and the banked
// memory stage (slave).
interface banked_mem_ctrl_if;
    import mem_pkg::*;

    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_in;
    logic                 wr;
    logic                 rd;
    logic [DATA_W-1:0]    data_out;
    logic [NUM_BANKS-1:0] busy;
    logic                 err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, busy, err
    );

endinterface

// File: rtl/banked_mem_ctrl_timer.sv
// Per-bank occupancy timer: loads on accept, counts down to zero, and
// flags the bank busy while the count is non-zero.
module mem_bank_timer #(
    parameter int CYCLES = 4,
    parameter int CNT_W  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             busy_reg;

    // Load only happens while idle, so load and decrement never compete.
    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = CNT_W'(CYCLES - 1);
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            busy_reg <= (cnt_next != '0);
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/banked_mem_ctrl.sv
// Four-bank word-interleaved main memory: single request port, per-bank
// occupancy timers, fixed-latency read pipeline with per-slot valid bits.
module banked_mem_ctrl
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    banked_mem_ctrl_if.slave  bus
);

    logic [BANK_W-1:0]    bank_sel;
    logic [ADDR_W-2:0]    word_idx;
    logic [NUM_BANKS-1:0] busy_vec;
    logic                 req_any;
    logic                 req_ok;
    logic                 rd_accept;
    logic                 wr_accept;

    assign bank_sel  = bank_of(bus.addr);
    assign word_idx  = bus.addr[ADDR_W-1:1];
    assign req_any   = bus.rd | bus.wr;
    assign req_ok    = (bus.rd ^ bus.wr) & ~bus.addr[0] & ~busy_vec[bank_sel];
    assign rd_accept = req_ok & bus.rd;
    assign wr_accept = req_ok & bus.wr;

    assign bus.err  = req_any & ~req_ok;
    assign bus.busy = busy_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            mem_bank_timer #(
                .CYCLES (BANK_CYCLES),
                .CNT_W  (CNT_W)
            ) u_timer (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (req_ok && (bank_sel == BANK_W'(gi))),
                .busy  (busy_vec[gi])
            );
        end
    endgenerate

    // Storage is deliberately not reset so it maps onto block RAM and keeps
    // its contents across a reset.
    logic [DATA_W-1:0] mem_array [NUM_WORDS];
    logic [DATA_W-1:0] ram_rd_reg;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_array[word_idx] <= bus.data_in;
        end
        if (rd_accept) begin
            ram_rd_reg <= mem_array[word_idx];
        end
    end

    // The RAM output register is the first latency stage; the remaining
    // RD_LATENCY-1 stages follow. Data stages carry no reset because the
    // valid bits alone decide what reaches data_out (needs RD_LATENCY >= 2).
    logic [DATA_W-1:0]     stage_reg [RD_LATENCY-1];
    logic [RD_LATENCY-1:0] vld_reg;

    always_ff @(posedge clk) begin
        stage_reg[0] <= ram_rd_reg;
        for (int i = 1; i < RD_LATENCY - 1; i++) begin
            stage_reg[i] <= stage_reg[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= {vld_reg[RD_LATENCY-2:0], rd_accept};
        end
    end

    assign bus.data_out = vld_reg[RD_LATENCY-1] ? stage_reg[RD_LATENCY-2] : '0;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Scoreboard bench for banked_mem_ctrl: driver predicts each cycle's
// err/busy and each read's return cycle; a negedge monitor compares.
module tb_banked_mem_ctrl;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    banked_mem_ctrl_if bus ();

    banked_mem_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic                 err;
        logic [NUM_BANKS-1:0] busy;
        err_cause_e           cause;
    } cyc_exp_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_exp_t;

    cyc_exp_t    exp_q[$];
    rd_exp_t     rd_q[$];
    logic [15:0] mem_model [int];
    int          free_at [NUM_BANKS];
    int          checks   = 0;
    int          failures = 0;

    // Reference model: a bank is busy until the cycle it was last claimed
    // plus BANK_CYCLES; a read returns RD_LATENCY cycles after it is accepted.
    task automatic step(input bit rst, input bit r, input bit w,
                        input logic [15:0] a, input logic [15:0] d);
        cyc_exp_t e;
        int       b;
        @(posedge clk);
        #1;
        rst_n       = ~rst;
        bus.rd      = r;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        b = int'(a[2:1]);
        if (rst) begin
            rd_q.delete();
            for (int k = 0; k < NUM_BANKS; k++) free_at[k] = 0;
        end
        for (int k = 0; k < NUM_BANKS; k++) e.busy[k] = (cyc < free_at[k]);
        if (!(r || w))        e.cause = ERR_NONE;
        else if (r && w)      e.cause = ERR_RD_WR;
        else if (a[0])        e.cause = ERR_MISALIGN;
        else if (e.busy[b])   e.cause = ERR_BANK_BUSY;
        else                  e.cause = ERR_NONE;
        e.err = (r || w) && (e.cause != ERR_NONE);
        if ((r || w) && e.cause == ERR_NONE) begin
            if (!rst) free_at[b] = cyc + BANK_CYCLES;
            if (w) mem_model[int'(a[15:1])] = d;
            if (r && !rst) rd_q.push_back('{cyc + RD_LATENCY, mem_model[int'(a[15:1])]});
        end
        exp_q.push_back(e);
        if (r || w)
            $display("txn cyc=%0d rst=%0b rd=%0b wr=%0b addr=%h data=%h expect=%s",
                     cyc, rst, r, w, a, d, e.cause.name());
    endtask

    always @(negedge clk) begin
        cyc_exp_t    e;
        logic [15:0] exp_data;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.err !== e.err) begin
                failures++;
                $display("FAIL err cyc=%0d got=%b exp=%b cause=%s", cyc, bus.err, e.err, e.cause.name());
            end
            checks++;
            if (bus.busy !== e.busy) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, e.busy);
            end
            exp_data = 16'h0000;
            if (rd_q.size() > 0 && rd_q[0].due == cyc) exp_data = rd_q.pop_front().data;
            checks++;
            if (bus.data_out !== exp_data) begin
                failures++;
                $display("FAIL data_out cyc=%0d got=%h exp=%h", cyc, bus.data_out, exp_data);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0000, 16'h0000);
    endtask

    initial begin
        int          pick;
        int          k;
        logic [15:0] a;
        rst_n       = 1'b0;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        for (int i = 0; i < NUM_BANKS; i++) free_at[i] = 0;

        // reset held with a read pending on the bus
        for (int i = 0; i < 3; i++) step(1, 1, 0, 16'h0010, 16'h0000);
        // write then read back, bank 0 occupancy window
        step(0, 0, 1, 16'h0010, 16'hBEEF);
        idle(3);
        step(0, 1, 0, 16'h0010, 16'h0000);
        idle(3);
        // one line across all four banks, back-to-back reads
        step(0, 0, 1, 16'h0100, 16'h1111);
        step(0, 0, 1, 16'h0102, 16'h2222);
        step(0, 0, 1, 16'h0104, 16'h3333);
        step(0, 0, 1, 16'h0106, 16'h4444);
        step(0, 1, 0, 16'h0100, 16'h0000);
        step(0, 1, 0, 16'h0102, 16'h0000);
        step(0, 1, 0, 16'h0104, 16'h0000);
        step(0, 1, 0, 16'h0106, 16'h0000);
        idle(3);
        // same-bank conflict
        step(0, 0, 1, 16'h0020, 16'hA5A5);
        idle(3);
        step(0, 1, 0, 16'h0020, 16'h0000);
        step(0, 1, 0, 16'h0028, 16'h0000);
        idle(3);
        // malformed requests
        step(0, 1, 1, 16'h0040, 16'h1234);
        step(0, 1, 0, 16'h0041, 16'h0000);
        idle(3);
        // top word and a read overlapped by a write to another bank
        step(0, 0, 1, 16'hFFFE, 16'hCAFE);
        step(0, 1, 0, 16'hFFFE, 16'h0000);
        step(0, 0, 1, 16'h0012, 16'h5555);
        idle(3);
        // reset mid-read, contents persist
        step(0, 1, 0, 16'h0010, 16'h0000);
        step(1, 0, 0, 16'h0000, 16'h0000);
        idle(2);
        step(0, 1, 0, 16'h0010, 16'h0000);
        idle(3);

        for (int n = 0; n < 200; n++) begin
            pick = $urandom_range(0, 19);
            k    = $urandom_range(0, 16);
            a    = (k == 16) ? 16'hFFFE : 16'h0200 + 16'(2 * k);
            if (pick < 2)                             idle(1);
            else if (pick == 2)                       step(0, 1, 1, a, 16'($urandom));
            else if (pick == 3)                       step(0, 1, 0, a | 16'h0001, 16'h0000);
            else if (pick == 19)                      step(1, 0, 0, 16'h0000, 16'h0000);
            else if (pick < 12 && mem_model.exists(int'(a[15:1])))
                                                      step(0, 1, 0, a, 16'h0000);
            else                                      step(0, 0, 1, a, 16'($urandom));
        end

        idle(RD_LATENCY + 3);
        @(negedge clk);
        #1;
        checks++;
        if (rd_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending_reads got=%0d exp=0", rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
